data_mem_resp: RTL and testbench



---
 rtl/data_mem_resp.sv | 131 +++++++++++++
 tb/tb_data_mem_resp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder for the core's M stage: combinational byte-lane reads,
// clocked byte-lane writes, reset-time zero clear, sticky fault capture, op counters.
module data_mem_resp #(
  parameter int DEPTH_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  memsize,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [AW-1:0]       idx;
  logic [3:0][7:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]       widx;
  logic [1:0]          lane;
  logic                illegal, oor, misal, access, bad, ok;
  logic [1:0]          code;
  logic [3:0]          be;
  logic [3:0][7:0]     wword;
  logic [3:0][7:0]     word;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;
  logic [31:0]         ext;

  assign widx = addr[AW+1:2];
  assign lane = addr[1:0];

  // Classification; illegal outranks range, range outranks alignment.
  always_comb begin
    illegal = (memsize == 3'b011) || (memsize == 3'b110) || (memsize == 3'b111) ||
              (we && re) || (we && memsize[2]);
    oor     = |addr[31:AW+2];
    misal   = ((memsize[1:0] == 2'b01) && addr[0]) ||
              ((memsize[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    access  = (we || re) && !busy;
    bad     = access && (illegal || oor || misal);
    ok      = access && !bad;
    if (illegal)  code = 2'b11;
    else if (oor) code = 2'b10;
    else          code = 2'b01;
  end

  always_comb begin
    be    = 4'b1111;
    wword = wdata;
    case (memsize[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[idx] <= '0;
    else if (ok && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][b] <= wword[b];
  end

  // Read path: pre-store contents are seen because the write lands at the edge.
  always_comb begin
    word  = mem[widx];
    rbyte = word[lane];
    rhalf = addr[1] ? {word[3], word[2]} : {word[1], word[0]};
    case (memsize)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext = {24'h0, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext = {16'h0, rhalf};
      3'b010:  ext = word;
      default: ext = '0;
    endcase
    rdata = (ok && re) ? ext : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? CLEAR : READY;
      busy       <= CLEAR_ON_RESET;
      idx        <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      fault_addr <= '0;
      load_cnt   <= '0;
      store_cnt  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == AW'(DEPTH_WORDS - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (bad && !fault) begin
            fault      <= 1'b1;
            fault_code <= code;
            fault_addr <= addr;
          end
          if (ok && re) load_cnt  <= load_cnt + 1'b1;
          if (ok && we) store_cnt <= store_cnt + 1'b1;
        end
        default: state <= READY;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: stimulus pushes expected values tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_data_mem_resp;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic        we, re;
  logic [2:0]  memsize;
  logic [31:0] rdata;
  logic        busy, fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_addr, load_cnt, store_cnt;

  data_mem_resp #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .memsize(memsize), .rdata(rdata), .busy(busy), .fault(fault),
    .fault_code(fault_code), .fault_addr(fault_addr),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_RDATA = 0, S_BUSY = 1, S_FAULT = 2, S_CODE = 3,
                 S_FADDR = 4, S_LCNT = 5, S_SCNT = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_RDATA: return rdata;
      S_BUSY:  return {31'h0, busy};
      S_FAULT: return {31'h0, fault};
      S_CODE:  return {30'h0, fault_code};
      S_FADDR: return fault_addr;
      S_LCNT:  return load_cnt;
      default: return store_cnt;
    endcase
  endfunction

  exp_t        e;
  logic [31:0] act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = pick(e.sel);
      compared++;
      if (act !== e.val) begin
        mismatched++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, e.cyc, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic w, input logic r, input logic [2:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; memsize = s; addr = a; wdata = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic ex(input string n, input int s, input logic [31:0] v);
    exp_t x;
    x.name = n; x.sel = s; x.val = v; x.cyc = cyc;
    q.push_back(x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    repeat (16) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    ex("rst_busy", S_BUSY, 1);
    ex("rst_fault", S_FAULT, 0);
    ex("rst_code", S_CODE, 0);
    ex("rst_faddr", S_FADDR, 0);
    ex("rst_lcnt", S_LCNT, 0);
    ex("rst_scnt", S_SCNT, 0);
    // Busy must hold for exactly 16 cycles
    for (int i = 0; i < 16; i++) begin
      ex("clear_busy", S_BUSY, 1);
      if (i == 5) begin
        drv(1'b0, 1'b1, 3'b010, 32'h3C, 32'h0);
        ex("lw_during_busy", S_RDATA, 32'h0);
      end else idle();
      step();
    end
    ex("clear_done", S_BUSY, 0);
    drv(1'b0, 1'b1, 3'b010, 32'h3C, 32'h0);
    ex("lw_after_clear", S_RDATA, 32'h0);
    step();

    // Reset again seven cycles into the clear
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ex("reclear_busy", S_BUSY, 1);
      if (i == 2) drv(1'b1, 1'b0, 3'b010, 32'h3C, 32'hDEADBEEF);
      else idle();
      step();
    end
    ex("reclear_done", S_BUSY, 0);
    ex("busy_store_cnt", S_SCNT, 0);
    drv(1'b0, 1'b1, 3'b010, 32'h3C, 32'h0);
    ex("busy_store_dropped", S_RDATA, 32'h0);
    step();

    // Byte lanes
    drv(1'b1, 1'b0, 3'b010, 32'h8, 32'h11223344); step();
    drv(1'b1, 1'b0, 3'b000, 32'hA, 32'h000000AA); step();
    drv(1'b1, 1'b0, 3'b001, 32'h8, 32'h0000BEEF); step();
    drv(1'b0, 1'b1, 3'b010, 32'h8, 32'h0);
    ex("lw_8", S_RDATA, 32'h11AABEEF);
    ex("lanes_scnt", S_SCNT, 3);
    step();
    drv(1'b0, 1'b1, 3'b000, 32'hA, 32'h0); ex("lb_a", S_RDATA, 32'hFFFFFFAA); step();
    drv(1'b0, 1'b1, 3'b100, 32'hA, 32'h0); ex("lbu_a", S_RDATA, 32'h000000AA); step();
    drv(1'b0, 1'b1, 3'b001, 32'h8, 32'h0); ex("lh_8", S_RDATA, 32'hFFFFBEEF); step();
    drv(1'b0, 1'b1, 3'b101, 32'hA, 32'h0); ex("lhu_a", S_RDATA, 32'h000011AA); step();
    idle();
    ex("lanes_lcnt", S_LCNT, 6);

    // Misalignment, then a second fault that must not overwrite the first
    drv(1'b0, 1'b1, 3'b010, 32'h6, 32'h0);
    ex("mis_rdata", S_RDATA, 32'h0);
    ex("mis_fault_pre", S_FAULT, 0);
    step();
    idle();
    ex("mis_fault", S_FAULT, 1);
    ex("mis_code", S_CODE, 2'b01);
    ex("mis_faddr", S_FADDR, 32'h6);
    ex("mis_lcnt", S_LCNT, 6);
    drv(1'b1, 1'b0, 3'b001, 32'h5, 32'h00001234);
    step();
    drv(1'b0, 1'b1, 3'b010, 32'h4, 32'h0);
    ex("mis_sh_nowrite", S_RDATA, 32'h0);
    ex("sticky_code", S_CODE, 2'b01);
    ex("sticky_faddr", S_FADDR, 32'h6);
    ex("mis_scnt", S_SCNT, 3);
    step();

    // Out of range
    do_reset();
    drv(1'b1, 1'b0, 3'b010, 32'h40, 32'h12345678);
    step();
    idle();
    ex("oor_fault", S_FAULT, 1);
    ex("oor_code", S_CODE, 2'b10);
    ex("oor_faddr", S_FADDR, 32'h40);
    ex("oor_scnt", S_SCNT, 0);
    step();

    // Illegal size
    do_reset();
    drv(1'b0, 1'b1, 3'b011, 32'h8, 32'h0);
    ex("ill_rdata", S_RDATA, 32'h0);
    step();
    idle();
    ex("ill_code", S_CODE, 2'b11);
    ex("ill_faddr", S_FADDR, 32'h8);
    step();

    // we and re together
    do_reset();
    drv(1'b1, 1'b1, 3'b010, 32'h10, 32'h55555555);
    ex("wr_rdata", S_RDATA, 32'h0);
    step();
    idle();
    ex("wr_code", S_CODE, 2'b11);
    ex("wr_faddr", S_FADDR, 32'h10);
    ex("wr_scnt", S_SCNT, 0);
    ex("wr_lcnt", S_LCNT, 0);
    drv(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    ex("wr_nowrite", S_RDATA, 32'h0);
    step();

    // Store then load next cycle
    drv(1'b1, 1'b0, 3'b010, 32'h4, 32'hCAFEF00D);
    ex("sw_no_re_rdata", S_RDATA, 32'h0);
    step();
    drv(1'b0, 1'b1, 3'b010, 32'h4, 32'h0);
    ex("lw_4", S_RDATA, 32'hCAFEF00D);
    ex("rdw_scnt", S_SCNT, 1);
    step();
    idle();
    ex("rdw_lcnt", S_LCNT, 2);
    step();
    step();

    if (q.size() != 0) begin
      $display("FAIL unchecked_expectations: got %0d left, expected 0", q.size());
      mismatched += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
